// File: rtl/pool_output_writer.sv
// pool_output_writer
//   Packs the signed byte stream from the ReLU/max-pooling stage into 16-bit
//   SRAM words, one independent packer per channel (A and B). The first byte
//   of a pair goes in the high half, the second byte in the low half. At end
//   of layer, a half-filled word on either channel is flushed with a zero low
//   byte, and then a one-cycle completion pulse is raised.
//
// Parameters
//   CH_A_BASE           first SRAM word address for channel A results
//   CH_B_BASE           first SRAM word address for channel B results
// Ports
//   clk                 clock, rising-edge active
//   reset_b             synchronous reset, active-high
//   dut_run             start pulse, accepted only in IDLE
//   valid_in[1:0]       0 idle, 1 channel A byte, 2 channel B byte, 3 end of layer
//   pool_data[7:0]      pooled byte, stored as raw bits
//   sram_write_enable   registered write strobe
//   sram_write_address  registered word address
//   sram_write_data     registered write word
//   dut_busy            high while a layer is in progress
//   layer_done          one-cycle completion pulse
module pool_output_writer #(
  parameter logic [11:0] CH_A_BASE = 12'h000,
  parameter logic [11:0] CH_B_BASE = 12'h080
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  input  logic [1:0]  valid_in,
  input  logic [7:0]  pool_data,
  output logic        sram_write_enable,
  output logic [11:0] sram_write_address,
  output logic [15:0] sram_write_data,
  output logic        dut_busy,
  output logic        layer_done
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FLUSH_A,
    FLUSH_B,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  hold_a, hold_a_n;
  logic [7:0]  hold_b, hold_b_n;
  logic        half_a, half_a_n;
  logic        half_b, half_b_n;
  logic [11:0] addr_a, addr_a_n;
  logic [11:0] addr_b, addr_b_n;
  logic        wr_en_n;
  logic [11:0] wr_addr_n;
  logic [15:0] wr_data_n;
  logic        busy_n;
  logic        done_n;

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state              <= IDLE;
      hold_a             <= '0;
      hold_b             <= '0;
      half_a             <= 1'b0;
      half_b             <= 1'b0;
      addr_a             <= '0;
      addr_b             <= '0;
      sram_write_enable  <= 1'b0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
      dut_busy           <= 1'b0;
      layer_done         <= 1'b0;
    end else begin
      state              <= state_n;
      hold_a             <= hold_a_n;
      hold_b             <= hold_b_n;
      half_a             <= half_a_n;
      half_b             <= half_b_n;
      addr_a             <= addr_a_n;
      addr_b             <= addr_b_n;
      sram_write_enable  <= wr_en_n;
      sram_write_address <= wr_addr_n;
      sram_write_data    <= wr_data_n;
      dut_busy           <= busy_n;
      layer_done         <= done_n;
    end
  end

  // Address/data output registers keep their last value when no write is
  // issued; only the enable strobe drops.
  always_comb begin
    state_n   = state;
    hold_a_n  = hold_a;
    hold_b_n  = hold_b;
    half_a_n  = half_a;
    half_b_n  = half_b;
    addr_a_n  = addr_a;
    addr_b_n  = addr_b;
    wr_en_n   = 1'b0;
    wr_addr_n = sram_write_address;
    wr_data_n = sram_write_data;
    busy_n    = dut_busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (dut_run) begin
          state_n  = COLLECT;
          addr_a_n = CH_A_BASE;
          addr_b_n = CH_B_BASE;
          half_a_n = 1'b0;
          half_b_n = 1'b0;
          busy_n   = 1'b1;
        end
      end

      COLLECT: begin
        case (valid_in)
          2'd1: begin
            if (!half_a) begin
              hold_a_n = pool_data;
              half_a_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr_a;
              wr_data_n = {hold_a, pool_data};
              addr_a_n  = addr_a + 12'd1;
              half_a_n  = 1'b0;
            end
          end
          2'd2: begin
            if (!half_b) begin
              hold_b_n = pool_data;
              half_b_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr_b;
              wr_data_n = {hold_b, pool_data};
              addr_b_n  = addr_b + 12'd1;
              half_b_n  = 1'b0;
            end
          end
          2'd3: state_n = FLUSH_A;
          default: ;
        endcase
      end

      FLUSH_A: begin
        if (half_a) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_a;
          wr_data_n = {hold_a, 8'h00};
          addr_a_n  = addr_a + 12'd1;
          half_a_n  = 1'b0;
        end
        state_n = FLUSH_B;
      end

      FLUSH_B: begin
        if (half_b) begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_b;
          wr_data_n = {hold_b, 8'h00};
          addr_b_n  = addr_b + 12'd1;
          half_b_n  = 1'b0;
        end
        state_n = DONE;
      end

      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
